// File: rtl/cpu_types_pkg.sv
// Shared cache/memory-control protocol types: machine word and RAM status code.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter.sv
// Memory-side responder: arbitrates instruction fetch and data access onto one RAM port,
// latching each granted request and holding it until RAM reports ACCESS.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic             dREN,
  input  logic             dWEN,
  input  word_t            iaddr,
  input  word_t            daddr,
  input  word_t            dstore,
  output logic             iwait,
  output logic             dwait,
  output word_t            iload,
  output word_t            dload,
  output logic             ramREN,
  output logic             ramWEN,
  output word_t            ramaddr,
  output word_t            ramstore,
  input  word_t            ramload,
  input  ramstate_t        ramstate,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    DREQ,
    IREQ
  } arb_state_t;

  arb_state_t       state_q, state_d;
  word_t            addr_q, addr_d;
  word_t            data_q, data_d;
  logic             wr_q, wr_d;
  word_t            iload_q, iload_d;
  word_t            dload_q, dload_d;
  logic [ERR_W-1:0] err_q, err_d;

  // NOTE: the RAM-facing address/data are driven straight from the latch registers, so
  // resetting those registers is what gives ramaddr/ramstore their reset value of zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    err_d    = err_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = addr_q;
    ramstore = data_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = iload_q;
    dload    = dload_q;

    unique case (state_q)
      IDLE: begin
        // Data wins a same-cycle tie; a combined read+write is a write.
        if (dREN || dWEN) begin
          addr_d  = daddr;
          data_d  = dstore;
          wr_d    = dWEN;
          state_d = DREQ;
        end else if (iREN) begin
          addr_d  = iaddr;
          wr_d    = 1'b0;
          state_d = IREQ;
        end
      end

      DREQ: begin
        ramREN = ~wr_q;
        ramWEN = wr_q;
        if (ramstate == ACCESS) begin
          dwait = 1'b0;
          if (!wr_q) begin
            dload   = ramload;
            dload_d = ramload;
          end
          // Hand over to a waiting fetch so data traffic cannot starve it.
          if (iREN) begin
            addr_d  = iaddr;
            wr_d    = 1'b0;
            state_d = IREQ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      IREQ: begin
        ramREN = 1'b1;
        if (ramstate == ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          iload_d = ramload;
          if (dREN || dWEN) begin
            addr_d  = daddr;
            data_d  = dstore;
            wr_d    = dWEN;
            state_d = DREQ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // ERROR keeps the transaction in place (retry); only the counter moves, saturating.
    if ((state_q != IDLE) && (ramstate == ERROR) && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  assign err_count = err_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences for
// error saturation and asynchronous reset during a data write.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  word_t     ramload;
  ramstate_t ramstate;

  logic       iwait, dwait, ramREN, ramWEN;
  word_t      iload, dload, ramaddr, ramstore;
  logic [7:0] err_count;

  logic       iwait2, dwait2, ramREN2, ramWEN2;
  word_t      iload2, dload2, ramaddr2, ramstore2;
  logic [1:0] err_count2;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ERR_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
  );

  mem_arbiter #(.ERR_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait2), .dwait(dwait2), .iload(iload2), .dload(dload2),
    .ramREN(ramREN2), .ramWEN(ramWEN2), .ramaddr(ramaddr2), .ramstore(ramstore2),
    .ramload(ramload), .ramstate(ramstate), .err_count(err_count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic      ir, dr, dw;
    word_t     ia, da, ds;
    ramstate_t rs;
    word_t     rl;
    logic      xiw, xdw, xren, xwen;
    word_t     xaddr, xstore, xil, xdl;
    logic [7:0] xerr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic ir, dr, dw, input word_t ia, da, ds,
                     input ramstate_t rs, input word_t rl,
                     input logic xiw, xdw, xren, xwen,
                     input word_t xaddr, xstore, xil, xdl, input logic [7:0] xerr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.xiw = xiw; v.xdw = xdw; v.xren = xren; v.xwen = xwen;
    v.xaddr = xaddr; v.xstore = xstore; v.xil = xil; v.xdl = xdl; v.xerr = xerr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ir, dr, dw, input word_t ia, da, ds,
                       input ramstate_t rs, input word_t rl);
    iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  int dwait_lows;

  initial begin
    // Fetch at 0x40 with two BUSY cycles.
    add(1,0,0, 32'h40, 0, 0, FREE,   0,            1,1,0,0, 32'h0,   32'h0,        32'h0,        32'h0,        0);
    add(0,0,0, 32'h40, 0, 0, BUSY,   0,            1,1,1,0, 32'h40,  32'h0,        32'h0,        32'h0,        0);
    add(0,0,0, 32'h40, 0, 0, BUSY,   0,            1,1,1,0, 32'h40,  32'h0,        32'h0,        32'h0,        0);
    add(0,0,0, 32'h40, 0, 0, ACCESS, 32'h20080004, 0,1,1,0, 32'h40,  32'h0,        32'h20080004, 32'h0,        0);
    // Simultaneous fetch + write: write first, address change ignored, fetch follows with no gap.
    add(1,0,1, 32'h80, 32'h100, 32'hDEADBEEF, FREE, 0, 1,1,0,0, 32'h40, 32'h0, 32'h20080004, 32'h0, 0);
    add(1,0,1, 32'h80, 32'h200, 32'h0, BUSY, 0,        1,1,0,1, 32'h100, 32'hDEADBEEF, 32'h20080004, 32'h0, 0);
    add(1,0,0, 32'h80, 32'h200, 32'h0, ACCESS, 32'h99999999, 1,0,0,1, 32'h100, 32'hDEADBEEF, 32'h20080004, 32'h0, 0);
    add(0,0,0, 32'h0, 32'h0, 32'h0, ACCESS, 32'h11112222,    0,1,1,0, 32'h80,  32'hDEADBEEF, 32'h11112222, 32'h0, 0);
    // Data read with three ERROR retries.
    add(0,1,0, 32'h0, 32'h300, 32'h0, FREE,  0, 1,1,0,0, 32'h80,  32'hDEADBEEF, 32'h11112222, 32'h0, 0);
    add(0,0,0, 32'h0, 32'h0,   32'h0, ERROR, 0, 1,1,1,0, 32'h300, 32'h0,        32'h11112222, 32'h0, 0);
    add(0,0,0, 32'h0, 32'h0,   32'h0, ERROR, 0, 1,1,1,0, 32'h300, 32'h0,        32'h11112222, 32'h0, 1);
    add(0,0,0, 32'h0, 32'h0,   32'h0, ERROR, 0, 1,1,1,0, 32'h300, 32'h0,        32'h11112222, 32'h0, 2);
    add(0,0,0, 32'h0, 32'h0,   32'h0, ACCESS, 32'hCAFE0001, 1,0,1,0, 32'h300, 32'h0, 32'h11112222, 32'hCAFE0001, 3);
    // dREN and dWEN together: a write, dload unchanged.
    add(0,1,1, 32'h0, 32'h400, 32'h55, FREE,   0, 1,1,0,0, 32'h300, 32'h0,  32'h11112222, 32'hCAFE0001, 3);
    add(0,0,0, 32'h0, 32'h0,   32'h0,  ACCESS, 0, 1,0,0,1, 32'h400, 32'h55, 32'h11112222, 32'hCAFE0001, 3);
    add(0,0,0, 32'h0, 32'h0,   32'h0,  FREE,   0, 1,1,0,0, 32'h400, 32'h55, 32'h11112222, 32'hCAFE0001, 3);
    // Fetch completing while data waits: DREQ follows directly.
    add(1,0,0, 32'hA0, 32'h0,   32'h0,  FREE,   0,     1,1,0,0, 32'h400, 32'h55, 32'h11112222, 32'hCAFE0001, 3);
    add(0,0,1, 32'h0,  32'h700, 32'h77, ACCESS, 32'h33, 0,1,1,0, 32'hA0,  32'h55, 32'h33,       32'hCAFE0001, 3);
    add(0,0,0, 32'h0,  32'h0,   32'h0,  ACCESS, 32'h44, 1,0,0,1, 32'h700, 32'h77, 32'h33,       32'hCAFE0001, 3);
    add(0,0,0, 32'h0,  32'h0,   32'h0,  FREE,   0,     1,1,0,0, 32'h700, 32'h77, 32'h33,       32'hCAFE0001, 3);

    // Reset with random inputs.
    nRST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
            $urandom, $urandom, $urandom, ramstate_t'($urandom_range(0,3)), $urandom);
      #1;
      check("rst_iwait", iwait, 1);
      check("rst_dwait", dwait, 1);
      check("rst_ren",   ramREN, 0);
      check("rst_wen",   ramWEN, 0);
      check("rst_err",   err_count, 0);
      check("rst_iload", iload, 0);
      check("rst_dload", dload, 0);
    end
    @(negedge CLK);
    drive(0,0,0, 0,0,0, FREE, 0);
    nRST = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].ia, vecs[i].da, vecs[i].ds,
            vecs[i].rs, vecs[i].rl);
      #1;
      check($sformatf("v%0d_iwait", i),    iwait,     vecs[i].xiw);
      check($sformatf("v%0d_dwait", i),    dwait,     vecs[i].xdw);
      check($sformatf("v%0d_ramREN", i),   ramREN,    vecs[i].xren);
      check($sformatf("v%0d_ramWEN", i),   ramWEN,    vecs[i].xwen);
      check($sformatf("v%0d_ramaddr", i),  ramaddr,   vecs[i].xaddr);
      check($sformatf("v%0d_ramstore", i), ramstore,  vecs[i].xstore);
      check($sformatf("v%0d_iload", i),    iload,     vecs[i].xil);
      check($sformatf("v%0d_dload", i),    dload,     vecs[i].xdl);
      check($sformatf("v%0d_err", i),      err_count, vecs[i].xerr);
      check($sformatf("v%0d_never_both", i), {31'b0, ~iwait & ~dwait}, 0);
    end
    check("err2_after_3", err_count2, 2'd3);

    // Five more ERROR retries on a read: wide counter reaches 8, narrow stays at 3.
    @(negedge CLK);
    drive(0,1,0, 0, 32'h500, 0, FREE, 0);
    dwait_lows = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      drive(0,0,0, 0,0,0, ERROR, 0);
      #1;
      check("err_hold_ren", ramREN, 1);
      check("err_hold_addr", ramaddr, 32'h500);
      if (!dwait) dwait_lows++;
    end
    @(negedge CLK);
    drive(0,0,0, 0,0,0, ACCESS, 32'h5A5A5A5A);
    #1;
    if (!dwait) dwait_lows++;
    check("err_dload", dload, 32'h5A5A5A5A);
    @(negedge CLK);
    drive(0,0,0, 0,0,0, FREE, 0);
    #1;
    if (!dwait) dwait_lows++;
    check("err_single_pulse", dwait_lows, 1);
    check("err_count_8", err_count, 8'd8);
    check("err2_saturated", err_count2, 2'd3);

    // Asynchronous reset in the middle of a data write.
    @(negedge CLK);
    drive(0,0,1, 0, 32'h600, 32'h1234, FREE, 0);
    @(negedge CLK);
    drive(0,0,0, 0,0,0, BUSY, 0);
    #1;
    check("arst_pre_wen", ramWEN, 1);
    #1;
    nRST = 1'b0;
    #1;
    check("arst_wen_drop", ramWEN, 0);
    check("arst_ren", ramREN, 0);
    check("arst_addr", ramaddr, 0);
    check("arst_err", err_count, 0);
    ramstate = ACCESS;
    #1;
    check("arst_no_dwait", dwait, 1);
    check("arst_no_iwait", iwait, 1);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("arst_idle_dwait", dwait, 1);
    check("arst_idle_wen", ramWEN, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter
